shf_pipe_shifter: RTL
=====================

// Module: shf_pipe_shifter
// PURPOSE
// Pipelined, parametrised barrel shifter for the FP datapath (exponent alignment, normalisation).
// - Shift direction is selected per transaction at run time.
// - Log-shifter levels are spread over NUM_STAGES register stages.
// - Valid/ready handshake at both ends; every stage collapses bubbles independently.
// - Optional sticky bit (OR of all bits shifted out on a right shift) for the FP rounding logic.
// PARAMETERS
// SIZE_DATA   24  data width in bits (>=2)
// SIZE_SHIFT  5   shift-amount width; amounts >= SIZE_DATA are out of range
// NUM_STAGES  2   pipeline register stages, 1..SIZE_SHIFT; latency in cycles
// PORTS
// i_clk           in   1           clock, all state on rising edge
// i_rst_n         in   1           asynchronous active-low reset
// i_valid         in   1           input beat valid
// o_ready         out  1           stage 0 can accept a beat
// i_dir           in   1           0 = shift left, 1 = shift right (logical, zero fill)
// i_shift_number  in   SIZE_SHIFT  shift amount
// i_data          in   SIZE_DATA   operand
// o_valid         out  1           output beat valid
// i_ready         in   1           downstream accepts the beat
// o_data          out  SIZE_DATA   shifted result
// o_sticky        out  1           OR of bits lost on a right shift; 0 for left shifts
// o_oor           out  1           i_shift_number >= SIZE_DATA for this beat
// BEHAVIOUR
// - Reset, async on i_rst_n low: all stage valids 0.
//   Reset values: o_valid=0, o_data=0, o_sticky=0, o_oor=0. o_ready=1 from the first edge after release.
// - Level assignment: level j shifts by 2^j. Stage k applies levels [k*L, min((k+1)*L, SIZE_SHIFT)),
//   where L = ceil(SIZE_SHIFT/NUM_STAGES). Each stage registers data, dir, remaining amount, sticky, oor.
// - Load rule: stage k loads when !valid_k || load_{k+1}. Last stage loads when !o_valid || i_ready.
//   o_ready = load_0. A beat transfers on i_valid && o_ready.
// - Latency is exactly NUM_STAGES cycles with no stall. Throughput is 1 beat/cycle.
//   Beats leave in input order; none is lost or duplicated.
// - Holding rule: o_data, o_sticky and o_oor stay stable while o_valid && !i_ready.
// - Out of range (amount >= SIZE_DATA, including non-power-of-2 SIZE_DATA): o_data = 0 and o_oor = 1.
//   o_sticky = |i_data for a right shift, 0 for a left shift.
// - Amount 0 passes data unchanged, sticky 0.
// - Simultaneous input accept and output drain on a full pipe is legal: occupancy is unchanged.
// - Reset mid-operation discards all in-flight beats; no partial output is produced.
// CONFIGURATION
// - SHF_STICKY_EN defined: each stage ORs the bits dropped by its right-shift levels into the carried sticky.
//   o_sticky behaves as above.
// - SHF_STICKY_EN undefined: no sticky logic or registers; o_sticky is tied to 0.
//   o_oor and o_data are unaffected.
// STRUCTURE
// - Package shf_pkg: typedef enum logic {SHF_LEFT=1'b0, SHF_RIGHT=1'b1} shf_dir_e.
//   Also a function returning levels-per-stage from (SIZE_SHIFT, NUM_STAGES).
// - Sub-module shf_pipe_stage: the combinational shift for one level group plus its valid/data registers.
//   Parameters: SIZE_DATA, SIZE_SHIFT, FIRST_LEVEL, NUM_LEVELS.
//   Instantiated NUM_STAGES times in a generate loop.
// - The top level holds only the load-chain wiring and the out-of-range decode at stage 0.
// TESTING (SIZE_DATA=24, SIZE_SHIFT=5, NUM_STAGES=2, SHF_STICKY_EN on unless noted)
// - Right shift, dir=1, amt=1, data=0x800001 -> o_data=0x400000, sticky=1, o_valid exactly 2 cycles later.
// - Left shift, dir=0, amt=23, data=0x000001 -> o_data=0x800000, sticky=0; amt=0 on 0xABCDEF -> 0xABCDEF.
// - Out of range, dir=1, amt=24..31, data=0xFFFFFF -> o_data=0, oor=1, sticky=1; same with dir=0 -> sticky=0.
// - Backpressure: i_ready=0 while 4 beats are offered -> o_ready drops after 2 accepted beats.
//   o_data held stable; after i_ready=1 the beats emerge in order with no loss.
// - Streaming: 100 random beats, i_ready=1 -> one result per cycle, matching the reference model.
// - Reset mid-flight: assert i_rst_n=0 with 2 beats in the pipe -> o_valid=0 immediately, no stale beat after release.
//   Rebuild with SHF_STICKY_EN off -> o_sticky constant 0.

Source files
------------

// File: rtl/shf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shf_pkg
// Description : Shared types and helpers for the pipelined barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shf_pkg;

    typedef enum logic {
        SHF_LEFT  = 1'b0,
        SHF_RIGHT = 1'b1
    } shf_dir_e;

    // Number of log-shifter levels each pipeline stage has to apply.
    function automatic int shf_levels_per_stage(input int size_shift, input int num_stages);
        return (size_shift + num_stages - 1) / num_stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shf_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : shf_pipe_stage
// Description : One pipeline stage: applies levels [FIRST_LEVEL, FIRST_LEVEL+NUM_LEVELS)
//               of the log shifter and registers the beat. Sticky carry under SHF_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shf_pipe_stage
    import shf_pkg::*;
#(
    parameter int SIZE_DATA   = 24,
    parameter int SIZE_SHIFT  = 5,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_valid,
    input  shf_dir_e              i_dir,
    input  logic [SIZE_SHIFT-1:0] i_amt,
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic                  i_oor,
`ifdef SHF_STICKY_EN
    input  logic                  i_sticky,
    output logic                  o_sticky,
`endif
    output logic                  o_valid,
    output shf_dir_e              o_dir,
    output logic [SIZE_SHIFT-1:0] o_amt,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic                  o_oor
);

    // Bits that a right shift by 2^lvl pushes off the bottom of the word.
    function automatic logic [SIZE_DATA-1:0] f_low_mask(input int lvl);
        logic [SIZE_DATA-1:0] m;
        for (int i = 0; i < SIZE_DATA; i++) begin
            m[i] = (i < (1 << lvl));
        end
        return m;
    endfunction

    logic [SIZE_DATA-1:0]  w_data;
    logic [SIZE_SHIFT-1:0] w_amt;
    logic                  r_valid;
    shf_dir_e              r_dir;
    logic [SIZE_SHIFT-1:0] r_amt;
    logic [SIZE_DATA-1:0]  r_data;
    logic                  r_oor;
`ifdef SHF_STICKY_EN
    logic                  w_sticky;
    logic                  r_sticky;
`endif

    always_comb begin
        w_data = i_data;
        w_amt  = i_amt;
`ifdef SHF_STICKY_EN
        w_sticky = i_sticky;
`endif
        for (int j = 0; j < NUM_LEVELS; j++) begin
            if (i_amt[FIRST_LEVEL + j]) begin
                if (i_dir == SHF_RIGHT) begin
`ifdef SHF_STICKY_EN
                    w_sticky = w_sticky | (|(w_data & f_low_mask(FIRST_LEVEL + j)));
`endif
                    w_data = w_data >> (1 << (FIRST_LEVEL + j));
                end else begin
                    w_data = w_data << (1 << (FIRST_LEVEL + j));
                end
            end
            // Consumed amount bits are cleared so only the remaining shift travels on.
            w_amt[FIRST_LEVEL + j] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_dir    <= SHF_LEFT;
            r_amt    <= '0;
            r_data   <= '0;
            r_oor    <= 1'b0;
`ifdef SHF_STICKY_EN
            r_sticky <= 1'b0;
`endif
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_dir    <= i_dir;
                r_amt    <= w_amt;
                r_data   <= w_data;
                r_oor    <= i_oor;
`ifdef SHF_STICKY_EN
                r_sticky <= w_sticky;
`endif
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_dir    = r_dir;
    assign o_amt    = r_amt;
    assign o_data   = r_data;
    assign o_oor    = r_oor;
`ifdef SHF_STICKY_EN
    assign o_sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: rtl/shf_pipe_shifter.sv
`default_nettype none
// ============================================================================
// Module      : shf_pipe_shifter
// Description : Pipelined left/right logical barrel shifter with valid/ready at both
//               ends. Define SHF_STICKY_EN to produce the right-shift sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shf_pipe_shifter
    import shf_pkg::*;
#(
    parameter int SIZE_DATA  = 24,
    parameter int SIZE_SHIFT = 5,
    parameter int NUM_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_dir,
    input  logic [SIZE_SHIFT-1:0] i_shift_number,
    input  logic [SIZE_DATA-1:0]  i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic                  o_sticky,
    output logic                  o_oor
);

    localparam int c_LEVELS = shf_levels_per_stage(SIZE_SHIFT, NUM_STAGES);

    logic [NUM_STAGES-1:0] w_vout;
    logic [NUM_STAGES-1:0] w_load;
    shf_dir_e              w_dir  [NUM_STAGES+1];
    logic [SIZE_SHIFT-1:0] w_amt  [NUM_STAGES+1];
    logic [SIZE_DATA-1:0]  w_data [NUM_STAGES+1];
    logic                  w_oor  [NUM_STAGES+1];
`ifdef SHF_STICKY_EN
    logic                  w_sticky [NUM_STAGES+1];
`endif
    logic                  w_unused_tail;

    // Out-of-range beats enter as zero data so the levels need no special case.
    assign w_oor[0]  = 32'(i_shift_number) >= SIZE_DATA;
    assign w_dir[0]  = shf_dir_e'(i_dir);
    assign w_amt[0]  = i_shift_number;
    assign w_data[0] = w_oor[0] ? '0 : i_data;
`ifdef SHF_STICKY_EN
    assign w_sticky[0] = w_oor[0] & (w_dir[0] == SHF_RIGHT) & (|i_data);
`endif

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int c_FIRST_RAW = k * c_LEVELS;
            localparam int c_FIRST     = (c_FIRST_RAW < SIZE_SHIFT) ? c_FIRST_RAW : SIZE_SHIFT;
            localparam int c_END       = (c_FIRST + c_LEVELS < SIZE_SHIFT) ? c_FIRST + c_LEVELS
                                                                           : SIZE_SHIFT;
            logic w_vin;

            if (k == 0) begin : g_first
                assign w_vin = i_valid;
            end else begin : g_inner
                assign w_vin = w_vout[k-1];
            end

            // Stage k loads unless it and every stage after it are full and the sink stalls.
            assign w_load[k] = i_ready | ~(&w_vout[NUM_STAGES-1:k]);

            shf_pipe_stage #(
                .SIZE_DATA   (SIZE_DATA),
                .SIZE_SHIFT  (SIZE_SHIFT),
                .FIRST_LEVEL (c_FIRST),
                .NUM_LEVELS  (c_END - c_FIRST)
            ) u_stage (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_load   (w_load[k]),
                .i_valid  (w_vin),
                .i_dir    (w_dir[k]),
                .i_amt    (w_amt[k]),
                .i_data   (w_data[k]),
                .i_oor    (w_oor[k]),
`ifdef SHF_STICKY_EN
                .i_sticky (w_sticky[k]),
                .o_sticky (w_sticky[k+1]),
`endif
                .o_valid  (w_vout[k]),
                .o_dir    (w_dir[k+1]),
                .o_amt    (w_amt[k+1]),
                .o_data   (w_data[k+1]),
                .o_oor    (w_oor[k+1])
            );
        end
    endgenerate

    assign o_ready = w_load[0];
    assign o_valid = w_vout[NUM_STAGES-1];
    assign o_data  = w_data[NUM_STAGES];
    assign o_oor   = w_oor[NUM_STAGES];
`ifdef SHF_STICKY_EN
    assign o_sticky = w_sticky[NUM_STAGES];
`else
    assign o_sticky = 1'b0;
`endif

    // Direction and residual amount are meaningless once the last level is applied.
    assign w_unused_tail = ^{w_dir[NUM_STAGES], w_amt[NUM_STAGES]};

endmodule
`default_nettype wire
